id_ex_stage: RTL

ID/EX pipeline stage of the five-stage RISC-V core. It sits directly downstream of the decode-stage control unit and register file. Each cycle it captures the 9-bit control bundle (Branch, Mem_to_Reg, Reg_Write, Mem_Read, Mem_Write, ALU_Src, ALU_Op[2:0]) and the decoded operands, and holds them for the execute stage. It also detects load-use hazards, inserts bubbles on stall or flush, and counts stall bubbles for performance monitoring.

---
 rtl/riscv_pipe_pkg.sv | 41 ++++
 rtl/hazard_detect_unit.sv | 30 +++
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: opcodes, ALU operation classes and the layout
// of the 9-bit control bundle carried from decode into execute.
package riscv_pipe_pkg;

  // Major opcodes decoded upstream
  localparam logic [6:0] R_Type       = 7'b0110011;
  localparam logic [6:0] I_Type_Logic = 7'b0010011;
  localparam logic [6:0] U_Type       = 7'b0110111;
  localparam logic [6:0] Load         = 7'b0000011;
  localparam logic [6:0] Store        = 7'b0100011;
  localparam logic [6:0] Branch       = 7'b1100011;

  // ALU operation classes
  localparam logic [2:0] AluOpRType  = 3'b000;
  localparam logic [2:0] AluOpIType  = 3'b001;
  localparam logic [2:0] AluOpMemAdd = 3'b010;
  localparam logic [2:0] AluOpBranch = 3'b011;
  localparam logic [2:0] AluOpUType  = 3'b100;

  // Control bundle layout, MSB first
  localparam int unsigned CTRL_WIDTH      = 9;
  localparam int unsigned CTRL_BRANCH     = 8;
  localparam int unsigned CTRL_MEM_TO_REG = 7;
  localparam int unsigned CTRL_REG_WRITE  = 6;
  localparam int unsigned CTRL_MEM_READ   = 5;
  localparam int unsigned CTRL_MEM_WRITE  = 4;
  localparam int unsigned CTRL_ALU_SRC    = 3;
  localparam int unsigned CTRL_ALU_OP_MSB = 2;
  localparam int unsigned CTRL_ALU_OP_LSB = 0;

  typedef logic [CTRL_WIDTH-1:0] ctrl_t;

  // Assemble the control bundle from individual decode signals
  function automatic ctrl_t pack_ctrl(input logic branch, input logic mem_to_reg,
                                      input logic reg_write, input logic mem_read,
                                      input logic mem_write, input logic alu_src,
                                      input logic [2:0] alu_op);
    return {branch, mem_to_reg, reg_write, mem_read, mem_write, alu_src, alu_op};
  endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detector: stalls decode when the instruction in EX is a
// load whose destination is read by the instruction currently in ID.
module hazard_detect_unit #(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      ex_valid,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_alu_src,
  input  logic                      id_mem_write,
  output logic                      stall
);

  logic rs2_used;
  logic rs1_hit;
  logic rs2_hit;

  // Stores read rs2 as data even though their ALU operand is the immediate
  always_comb begin
    rs2_used = !id_alu_src || id_mem_write;
    rs1_hit  = (ex_rd_addr == id_rs1_addr);
    rs2_hit  = (ex_rd_addr == id_rs2_addr) && rs2_used;
    // x0 is never a real producer, so it cannot create a dependency
    stall    = ex_valid && ex_mem_read && (ex_rd_addr != '0) && id_valid && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion
// on stall or flush, and a saturating stall-bubble counter.
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter int unsigned BUBBLE_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        id_valid_i,
  input  logic                        branch_i,
  input  logic                        mem_to_reg_i,
  input  logic                        reg_write_i,
  input  logic                        mem_read_i,
  input  logic                        mem_write_i,
  input  logic                        alu_src_i,
  input  logic [2:0]                  alu_op_i,
  input  logic [DATA_WIDTH-1:0]       pc_i,
  input  logic [DATA_WIDTH-1:0]       rs1_data_i,
  input  logic [DATA_WIDTH-1:0]       rs2_data_i,
  input  logic [DATA_WIDTH-1:0]       imm_i,
  input  logic [REG_ADDR_WIDTH-1:0]   rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0]   rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0]   rd_addr_i,
  input  logic [2:0]                  funct3_i,
  input  logic                        funct7_b30_i,
  input  logic                        flush_i,
  output logic                        ex_valid_o,
  output logic                        branch_o,
  output logic                        mem_to_reg_o,
  output logic                        reg_write_o,
  output logic                        mem_read_o,
  output logic                        mem_write_o,
  output logic                        alu_src_o,
  output logic [2:0]                  alu_op_o,
  output logic [DATA_WIDTH-1:0]       pc_o,
  output logic [DATA_WIDTH-1:0]       rs1_data_o,
  output logic [DATA_WIDTH-1:0]       rs2_data_o,
  output logic [DATA_WIDTH-1:0]       imm_o,
  output logic [REG_ADDR_WIDTH-1:0]   rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0]   rs2_addr_o,
  output logic [REG_ADDR_WIDTH-1:0]   rd_addr_o,
  output logic [2:0]                  funct3_o,
  output logic                        funct7_b30_o,
  output logic                        stall_o,
  output logic [BUBBLE_CNT_WIDTH-1:0] bubble_cnt_o
);

  typedef struct packed {
    logic                      valid;
    ctrl_t                     ctrl;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]                funct3;
    logic                      funct7_b30;
  } ex_slot_t;

  ex_slot_t                    ex_q, ex_d;
  logic [BUBBLE_CNT_WIDTH-1:0] cnt_q, cnt_d;
  ctrl_t                       id_ctrl;
  logic                        stall;

  hazard_detect_unit #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_hazard (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.ctrl[CTRL_MEM_READ]),
    .ex_rd_addr  (ex_q.rd_addr),
    .id_valid    (id_valid_i),
    .id_rs1_addr (rs1_addr_i),
    .id_rs2_addr (rs2_addr_i),
    .id_alu_src  (alu_src_i),
    .id_mem_write(mem_write_i),
    .stall       (stall)
  );

  // Next EX slot contents: flush beats stall, stall beats normal capture
  always_comb begin
    id_ctrl = pack_ctrl(branch_i, mem_to_reg_i, reg_write_i, mem_read_i, mem_write_i,
                        alu_src_i, alu_op_i);
    ex_d    = '0;
    cnt_d   = cnt_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d = '0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + BUBBLE_CNT_WIDTH'(1);
      end
    end else begin
      ex_d.valid      = id_valid_i;
      // An invalid slot must never carry live control into EX
      ex_d.ctrl       = id_valid_i ? id_ctrl : '0;
      ex_d.pc         = pc_i;
      ex_d.rs1_data   = rs1_data_i;
      ex_d.rs2_data   = rs2_data_i;
      ex_d.imm        = imm_i;
      ex_d.rs1_addr   = rs1_addr_i;
      ex_d.rs2_addr   = rs2_addr_i;
      ex_d.rd_addr    = rd_addr_i;
      ex_d.funct3     = funct3_i;
      ex_d.funct7_b30 = funct7_b30_i;
    end
  end

  // Pipeline register and bubble counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  // Output fan-out from the registered slot
  always_comb begin
    ex_valid_o   = ex_q.valid;
    branch_o     = ex_q.ctrl[CTRL_BRANCH];
    mem_to_reg_o = ex_q.ctrl[CTRL_MEM_TO_REG];
    reg_write_o  = ex_q.ctrl[CTRL_REG_WRITE];
    mem_read_o   = ex_q.ctrl[CTRL_MEM_READ];
    mem_write_o  = ex_q.ctrl[CTRL_MEM_WRITE];
    alu_src_o    = ex_q.ctrl[CTRL_ALU_SRC];
    alu_op_o     = ex_q.ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB];
    pc_o         = ex_q.pc;
    rs1_data_o   = ex_q.rs1_data;
    rs2_data_o   = ex_q.rs2_data;
    imm_o        = ex_q.imm;
    rs1_addr_o   = ex_q.rs1_addr;
    rs2_addr_o   = ex_q.rs2_addr;
    rd_addr_o    = ex_q.rd_addr;
    funct3_o     = ex_q.funct3;
    funct7_b30_o = ex_q.funct7_b30;
    stall_o      = stall;
    bubble_cnt_o = cnt_q;
  end

endmodule
